// File: rtl/ikaopm_regwr_sched.sv
// Register-write scheduler: latches the CPU address, holds one pending data write
// and releases it to the register file in the phi1 slot that owns the target register.
module ikaopm_regwr_sched #(
   parameter int BUSY_CYCLES = 64
) (
   input  logic       i_EMUCLK,
   input  logic       i_RST,
   input  logic       i_phi1_NCEN_n,
   input  logic       i_CYCLE_01,
   input  logic       i_WR,
   input  logic       i_A0,
   input  logic [7:0] i_DIN,
   output logic [7:0] o_ADDR,
   output logic       o_BUSY,
   output logic       o_DROP,
   output logic       o_REG_WE,
   output logic [7:0] o_REG_ADDR,
   output logic [7:0] o_REG_DATA,
   output logic [4:0] o_SLOT,
   output logic       o_SLOT_VALID
);

   typedef enum logic [1:0] {IDLE, PEND, ISSUE, HOLD} state_t;

   state_t     state, state_nxt;
   logic       cen, addr_wr, data_wr;
   logic [4:0] slot_nxt, tgt;
   logic [7:0] hold;

   assign cen     = ~i_phi1_NCEN_n;
   assign addr_wr = i_WR & ~i_A0;
   assign data_wr = i_WR & i_A0;

   function automatic logic [4:0] target_slot(input logic [7:0] a);
      if (a < 8'h20)      return 5'd0;
      else if (a < 8'h40) return {2'b00, a[2:0]};
      else                return a[4:0];
   endfunction

   // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
   always_comb begin
      slot_nxt = 5'd0;
      if (i_CYCLE_01)        slot_nxt = 5'd1;
      else if (o_SLOT_VALID) slot_nxt = o_SLOT + 5'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (data_wr) state_nxt = PEND;
         PEND:    if (cen && o_SLOT_VALID && slot_nxt == tgt) state_nxt = ISSUE;
         ISSUE:   if (cen) state_nxt = HOLD;
         HOLD:    if (cen && hold == 8'd1) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The write enable is a pure decode of the state register, so reset drops it at once.
   always_comb begin
      o_REG_WE = (state == ISSUE);
   end

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         o_SLOT       <= 5'd0;
         o_SLOT_VALID <= 1'b0;
         o_ADDR       <= 8'h00;
         o_REG_ADDR   <= 8'h00;
         o_REG_DATA   <= 8'h00;
         o_BUSY       <= 1'b0;
         o_DROP       <= 1'b0;
         tgt          <= 5'd0;
         hold         <= 8'd0;
      end else begin
         o_BUSY <= (state != IDLE);
         if (cen) begin
            o_SLOT <= slot_nxt;
            if (i_CYCLE_01) o_SLOT_VALID <= 1'b1;
         end
         if (addr_wr) o_ADDR <= i_DIN;
         if (data_wr) begin
            if (state == IDLE) begin
               o_REG_ADDR <= o_ADDR;
               o_REG_DATA <= i_DIN;
               tgt        <= target_slot(o_ADDR);
            end else begin
               o_DROP <= 1'b1;
            end
         end
         if (cen) begin
            if (state == ISSUE)                    hold <= 8'(BUSY_CYCLES);
            else if (state == HOLD && hold != 8'd0) hold <= hold - 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_ikaopm_regwr_sched.sv
// Bench for ikaopm_regwr_sched: directed table, hand-written corner sequences and a
// randomized run compared each clock against a deadline-based reference model.
module tb_ikaopm_regwr_sched;

   localparam int B = 64;

   logic       clk = 1'b0;
   logic       i_RST, i_phi1_NCEN_n, i_CYCLE_01, i_WR, i_A0;
   logic [7:0] i_DIN;
   logic [7:0] o_ADDR, o_REG_ADDR, o_REG_DATA;
   logic       o_BUSY, o_DROP, o_REG_WE, o_SLOT_VALID;
   logic [4:0] o_SLOT;

   ikaopm_regwr_sched #(.BUSY_CYCLES(B)) dut (
      .i_EMUCLK(clk), .i_RST(i_RST), .i_phi1_NCEN_n(i_phi1_NCEN_n), .i_CYCLE_01(i_CYCLE_01),
      .i_WR(i_WR), .i_A0(i_A0), .i_DIN(i_DIN), .o_ADDR(o_ADDR), .o_BUSY(o_BUSY),
      .o_DROP(o_DROP), .o_REG_WE(o_REG_WE), .o_REG_ADDR(o_REG_ADDR), .o_REG_DATA(o_REG_DATA),
      .o_SLOT(o_SLOT), .o_SLOT_VALID(o_SLOT_VALID)
   );

   always #5 clk = ~clk;

   int n_pass = 0, n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // Reference model: a pending write is tracked as a cen count against an issue deadline.
   logic [4:0] m_slot, m_target;
   logic       m_valid, m_busy, m_drop, m_active, m_we;
   logic [7:0] m_addr, m_raddr, m_rdata;
   int         m_cnt, m_wait;   // m_wait == 0: deadline not yet known (slots unaligned)

   function automatic logic [4:0] tslot(input logic [7:0] a);
      if (a < 8'h20) return 5'd0;
      if (a < 8'h40) return 5'(a % 8);
      return 5'(a % 32);
   endfunction

   task automatic model_step(input logic rst, input logic cen, input logic cyc,
                             input logic wr, input logic a0, input logic [7:0] din);
      logic       pre_active;
      logic [4:0] nslot;
      if (rst) begin
         m_slot = 0; m_valid = 0; m_busy = 0; m_drop = 0; m_active = 0; m_we = 0;
         m_addr = 0; m_raddr = 0; m_rdata = 0; m_target = 0; m_cnt = 0; m_wait = 0;
      end else begin
         pre_active = m_active;
         m_busy = pre_active;
         nslot = cyc ? 5'd1 : (m_valid ? 5'((int'(m_slot) + 1) % 32) : 5'd0);
         if (pre_active && cen) begin
            m_cnt++;
            if (m_wait == 0 && m_valid && nslot == m_target) m_wait = m_cnt;
            if (m_wait != 0 && m_cnt == m_wait + 1 + B) m_active = 0;
         end
         if (cen) begin
            m_slot = nslot;
            if (cyc) m_valid = 1;
         end
         if (wr && a0) begin
            if (pre_active) m_drop = 1;
            else begin
               m_raddr = m_addr; m_rdata = din; m_target = tslot(m_addr);
               m_active = 1; m_cnt = 0;
               m_wait = m_valid ? ((int'(m_target) - int'(m_slot) - 1 + 64) % 32) + 1 : 0;
            end
         end
         if (wr && !a0) m_addr = din;
         m_we = m_active && m_wait != 0 && m_cnt == m_wait;
      end
   endtask

   task automatic compare_all();
      check("addr", o_ADDR, m_addr);
      check("busy", o_BUSY, m_busy);
      check("drop", o_DROP, m_drop);
      check("reg_we", o_REG_WE, m_we);
      check("reg_addr", o_REG_ADDR, m_raddr);
      check("reg_data", o_REG_DATA, m_rdata);
      check("slot", o_SLOT, m_slot);
      check("slot_valid", o_SLOT_VALID, m_valid);
   endtask

   logic cen_rand = 0, force_cyc = 0, last_cen = 0, prev_we = 0, saw_bb = 0;
   int   phase_ctr = 0, we_pulses = 0;

   task automatic step(input logic rst, input logic wr, input logic a0, input logic [7:0] din);
      logic cen, cyc;
      cen = cen_rand ? ($urandom_range(0, 1) == 1) : (phase_ctr % 2 == 0);
      phase_ctr++;
      cyc = cen && (force_cyc || (m_valid && m_slot == 5'd0));
      if (cyc) force_cyc = 0;
      i_RST = rst; i_phi1_NCEN_n = ~cen; i_CYCLE_01 = cyc; i_WR = wr; i_A0 = a0; i_DIN = din;
      @(posedge clk); #1;
      model_step(rst, cen, cyc, wr, a0, din);
      last_cen = cen;
      compare_all();
      if (o_REG_WE && !prev_we) we_pulses++;
      prev_we = o_REG_WE;
      if (o_REG_DATA == 8'hBB) saw_bb = 1;
      i_WR = 0;
   endtask

   task automatic wait_we(input int max_steps, output int cens, output logic ok);
      cens = 0; ok = 0;
      for (int i = 0; i < max_steps; i++) begin
         step(0, 0, 0, 8'h00);
         if (last_cen) cens++;
         if (o_REG_WE) begin ok = 1; break; end
      end
      check("we_timeout", ok, 1);
   endtask

   task automatic wait_idle(input int max_steps);
      logic ok = 0;
      for (int i = 0; i < max_steps; i++) begin
         step(0, 0, 0, 8'h00);
         if (!o_BUSY) begin ok = 1; break; end
      end
      check("idle_timeout", ok, 1);
   endtask

   task automatic align();
      force_cyc = 1;
      for (int i = 0; i < 8 && !m_valid; i++) step(0, 0, 0, 8'h00);
      check("align", o_SLOT_VALID, 1);
   endtask

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic [4:0] slot;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int   lat, cnt;
      logic ok;
      logic [7:0] a;
      vecs[0] = '{8'h6B, 8'h1F, 5'd11};
      vecs[1] = '{8'h1F, 8'h01, 5'd0};
      vecs[2] = '{8'h20, 8'h02, 5'd0};
      vecs[3] = '{8'h25, 8'h03, 5'd5};
      vecs[4] = '{8'h3F, 8'h04, 5'd7};
      vecs[5] = '{8'h40, 8'h05, 5'd0};
      vecs[6] = '{8'hFF, 8'h06, 5'd31};
      vecs[7] = '{8'h5E, 8'h07, 5'd30};
      vecs[8] = '{8'h3A, 8'h08, 5'd2};
      vecs[9] = '{8'hC1, 8'h09, 5'd1};

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         i_RST = 1; i_phi1_NCEN_n = 1'($urandom); i_CYCLE_01 = 1'($urandom);
         i_WR = 1'($urandom); i_A0 = 1'($urandom); i_DIN = 8'($urandom);
         @(posedge clk); #1;
         model_step(1, 0, 0, 0, 0, 8'h00);
      end
      check("rst_outputs", {o_ADDR, o_BUSY, o_DROP, o_REG_WE, o_REG_ADDR, o_REG_DATA, o_SLOT, o_SLOT_VALID}, 0);
      i_WR = 0;
      align();
      for (int i = 0; i < 80; i++) step(0, 0, 0, 8'h00);
      check("no_we_without_write", we_pulses, 0);

      // Global register: slot 0, then BUSY hold length counted in cens
      step(0, 1, 0, 8'h08);
      step(0, 1, 1, 8'h55);
      wait_we(100, lat, ok);
      if (ok) begin
         check("glob_slot", o_SLOT, 0);
         check("glob_addr", o_REG_ADDR, 8'h08);
         check("glob_data", o_REG_DATA, 8'h55);
         for (int i = 0; i < 10 && o_REG_WE; i++) begin
            step(0, 0, 0, 8'h00);
            if (o_REG_WE) check("glob_slot_hold", o_SLOT, 0);
         end
         cnt = 0;
         for (int i = 0; i < 400; i++) begin
            step(0, 0, 0, 8'h00);
            if (last_cen) cnt++;
            if (!o_BUSY) break;
         end
         check("busy_hold_cens", cnt, B);
      end

      // Table of target-slot vectors
      foreach (vecs[k]) begin
         wait_idle(600);
         step(0, 1, 0, vecs[k].addr);
         step(0, 1, 1, vecs[k].data);
         wait_we(100, lat, ok);
         if (ok) begin
            check("vec_slot", o_SLOT, vecs[k].slot);
            check("vec_addr", o_REG_ADDR, vecs[k].addr);
            check("vec_data", o_REG_DATA, vecs[k].data);
            check("vec_latency", (lat >= 1 && lat <= 32), 1);
         end
      end
      wait_idle(600);

      // Data write while busy is dropped
      we_pulses = 0; saw_bb = 0;
      step(0, 1, 0, 8'h40);
      step(0, 1, 1, 8'hAA);
      step(0, 0, 0, 8'h00);
      check("busy_after_accept", o_BUSY, 1);
      step(0, 1, 1, 8'hBB);
      check("drop_set", o_DROP, 1);
      wait_we(100, lat, ok);
      if (ok) check("busy_wr_data", o_REG_DATA, 8'hAA);
      wait_idle(600);
      check("busy_wr_pulses", we_pulses, 1);
      check("never_bb", saw_bb, 0);

      // Reset while pending
      a = {3'b010, 5'(m_slot + 5'd16)};
      we_pulses = 0;
      step(0, 1, 0, a);
      step(0, 1, 1, 8'h12);
      step(0, 0, 0, 8'h00);
      step(0, 0, 0, 8'h00);
      check("pend_busy", o_BUSY, 1);
      step(1, 0, 0, 8'h00);
      check("rst_pend_busy", o_BUSY, 0);
      check("rst_pend_we", o_REG_WE, 0);
      check("rst_pend_valid", o_SLOT_VALID, 0);
      for (int i = 0; i < 80; i++) step(0, 0, 0, 8'h00);
      check("rst_pend_no_we", we_pulses, 0);

      // Write before alignment waits, then issues once slots align
      step(0, 1, 0, 8'h45);
      step(0, 1, 1, 8'h77);
      for (int i = 0; i < 60; i++) step(0, 0, 0, 8'h00);
      check("prealign_no_we", we_pulses, 0);
      check("prealign_busy", o_BUSY, 1);
      force_cyc = 1;
      wait_we(200, lat, ok);
      if (ok) begin
         check("prealign_slot", o_SLOT, 5);
         check("prealign_data", o_REG_DATA, 8'h77);
      end
      wait_idle(600);

      // Randomized run against the model
      for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00);
      cen_rand = 1;
      force_cyc = 1;
      for (int i = 0; i < 4000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 4)      step(0, 1, 0, 8'($urandom));
         else if (r < 8) step(0, 1, 1, 8'($urandom));
         else            step(0, 0, 0, 8'h00);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ikaopm_regwr_sched.md
# ikaopm_regwr_sched

Register-write scheduler between the CPU bus interface and the OPM register file. It latches the register address, holds one pending data write, and issues that write to the register file only in the phi1 cycle slot that owns the target register. Slot tracking is driven by the timing generator's `CYCLE_01` decode. It also produces the chip's BUSY flag, which stays high from data-write acceptance until a fixed hold period after the issue.

## Interface

Parameters:
- `BUSY_CYCLES`, default 64: number of phi1 cycles BUSY stays high after the write strobe ends. Legal range 1..255.

Ports:
- `i_EMUCLK` in 1: emulator master clock; all state changes on its rising edge.
- `i_RST` in 1: reset, synchronous, active-high; takes effect on any `i_EMUCLK` edge, independent of clock enables.
- `i_phi1_NCEN_n` in 1: phi1 negative-edge clock enable (active-low). A "cen" below is an `i_EMUCLK` edge with this input low.
- `i_CYCLE_01` in 1: timing-generator decode; high during the phi1 period of cycle 1.
- `i_WR` in 1: CPU write strobe, one `i_EMUCLK` wide.
- `i_A0` in 1: 0 = address write, 1 = data write.
- `i_DIN` in 8: CPU write data.
- `o_ADDR` out 8: current address latch.
- `o_BUSY` out 1: BUSY flag.
- `o_DROP` out 1: sticky flag; a data write arrived while busy.
- `o_REG_WE` out 1: register-file write enable.
- `o_REG_ADDR` out 8: register-file write address.
- `o_REG_DATA` out 8: register-file write data.
- `o_SLOT` out 5: current slot number.
- `o_SLOT_VALID` out 1: slot counter is aligned.

## Operation

- **Reset values:** every output is 0 and the state machine is in `IDLE`.
- **Slot counter** (updates on cen only):
  - If `i_CYCLE_01`=1, next slot = 1 and `o_SLOT_VALID` is set.
  - Otherwise, if `o_SLOT_VALID`=1, next slot = slot+1, wrapping 31→0.
  - Otherwise the slot stays 0.
- **Address write** (`i_WR`=1, `i_A0`=0):
  - `o_ADDR` <= `i_DIN` on the same `i_EMUCLK` edge, with no cen needed.
  - Allowed in any state. It does not affect a write already accepted.
- **Data write** (`i_WR`=1, `i_A0`=1):
  - In `IDLE`: snapshot `o_ADDR` into `o_REG_ADDR` and `i_DIN` into `o_REG_DATA`, compute the target slot, and go to `PEND`. This happens on that `i_EMUCLK` edge, with no cen needed.
  - In any other state: the write is discarded, `o_DROP` <= 1, and `o_REG_ADDR`/`o_REG_DATA` are unchanged.
- **Target slot:**
  - addr < 0x20 → slot 0.
  - 0x20..0x3F → `{2'b00, addr[2:0]}`.
  - ≥ 0x40 → `addr[4:0]`.
- **State machine** (transitions on cen unless noted):
  - `IDLE`: waits for a data write; this transition is `i_EMUCLK`-level.
  - `PEND`: if `o_SLOT_VALID`=1 and the next slot equals the target, then `o_REG_WE` <= 1 and go to `ISSUE`.
  - `ISSUE`: `o_REG_WE` <= 0, load the hold counter with `BUSY_CYCLES`, go to `HOLD`.
  - `HOLD`: decrement the hold counter; on the cen where it equals 1, go to `IDLE`.
- `o_BUSY` = (state != `IDLE`), registered.
- Hold counter is 8 bits and never underflows.

## Timing

- A data write accepted on a cen edge is first evaluated for issue at the following cen, never at the same edge.
- `o_REG_WE` is high for exactly one phi1 period, the one during which `o_SLOT` equals the target. `o_REG_ADDR` and `o_REG_DATA` are stable for that whole period.
- Issue latency from acceptance is 1..32 cens once the slot counter is aligned. Before the first `i_CYCLE_01`, the write waits in `PEND` indefinitely.
- `o_BUSY` rises one `i_EMUCLK` after acceptance. It falls `BUSY_CYCLES` cens after the cen where `o_REG_WE` falls.
- **Reset mid-operation:** the pending write is discarded, `o_REG_WE` goes low immediately, and slot alignment is lost.
- `i_WR` with `i_RST`=1 is ignored.
- `i_CYCLE_01` arriving while the counter is already aligned re-forces slot 1. This is harmless when the two agree.

## Test plan

- **Reset:** hold `i_RST` 3 clocks with random inputs → all outputs 0, `o_SLOT_VALID`=0, and no `o_REG_WE` until a data write arrives.
- **Global register:** address 0x08, then data 0x55 after alignment → one `o_REG_WE` period with `o_SLOT`=0, `o_REG_ADDR`=0x08, `o_REG_DATA`=0x55. `o_BUSY` falls exactly 64 cens after `o_REG_WE` falls.
- **Operator register:** address 0x6B, then data 0x1F → `o_REG_WE` only during slot 11, and never more than 32 cens after acceptance.
- **Write while busy:** data 0xAA accepted, then data 0xBB while `o_BUSY`=1 → `o_DROP`=1, only 0xAA is written, and `o_REG_DATA` never shows 0xBB.
- **Reset in `PEND`:** assert `i_RST` while in `PEND` → `o_REG_WE` never pulses, and `o_BUSY`=0 on the next edge.
- **Pre-alignment write:** data write before any `i_CYCLE_01` → stays in `PEND`; after the first `i_CYCLE_01`, it issues in the correct slot of that frame or the next.
